seq_multiplier: RTL

- Parametrised, iterative radix-2 shift-add multiplier for the CPU datapath.
- Replaces the single-cycle combinational multiply with a multi-cycle unit that trades latency for area.
- Supports signed and unsigned operands, selected per operation.
- Uses a start/busy/done handshake driven by the control unit; result is held until the next operation completes.

---
 rtl/seq_multiplier.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier -- iterative radix-2 shift-add multiplier.
//
// Computes a*b over WIDTH+1 clock cycles, treating the operands as
// unsigned or two's-complement according to is_signed.
// Signed operands are reduced to magnitudes and the sign is applied
// once at the end.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request a multiply (sampled only in IDLE)
//   is_signed   in   1 = two's-complement operands, 0 = unsigned
//   a, b        in   WIDTH-bit multiplicand / multiplier, captured with start
//   busy        out  high while an operation is in progress
//   done        out  one-cycle pulse when product is updated
//   product     out  2*WIDTH-bit registered result, held between operations
//   ovf         out  (only with MUL_OVF_EN) result does not fit in WIDTH bits
//   o_dbg_state out  current FSM state (0=IDLE, 1=RUN, 2=FINISH)
//
// Handshake: start is accepted on any rising edge where the unit is in
// IDLE (busy=0). This includes the cycle in which done is high. busy
// rises from that edge and stays high for WIDTH+1 cycles. start, a, b
// and is_signed are ignored while busy=1. done pulses for exactly one
// cycle, and the new product is valid in the same cycle.
//
// Optional feature macro: MUL_OVF_EN adds the ovf output.

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
`ifdef MUL_OVF_EN
  output logic               ovf,
`endif
  output logic [1:0]         o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right each iteration
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_signed;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_result;
  logic               w_accept;
  logic               w_last_iter;

  // -2^(WIDTH-1) negates to itself.
  // Read as unsigned, that value is the correct magnitude.
  assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_result    = r_neg ? -r_acc : r_acc;

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_RUN;
      S_RUN:    if (w_last_iter) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_signed <= is_signed;
      end else if (r_state == S_RUN) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end else if (r_state == S_FINISH) begin
        product <= w_result;
        done    <= 1'b1;
      end
    end
  end

`ifdef MUL_OVF_EN
  logic [WIDTH:0] w_hi;   // bits that must be pure sign extension when signed
  logic           w_ovf;

  assign w_hi  = w_result[2*WIDTH-1:WIDTH-1];
  assign w_ovf = r_signed ? !((w_hi == '0) || (w_hi == '1))
                          : (w_result[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf <= 1'b0;
    else if (r_state == S_FINISH)  ovf <= w_ovf;
  end
`endif

endmodule
